// File: rtl/alu_pkg.sv
// alu_pkg: opcode/funct constants, instruction format enum and the issue packet
// shared by the ALU issue stage and its register file.
package alu_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_AND     = 3'b111;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_WORD    = 3'b010;
    localparam logic [2:0] F3_BEQ     = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_ILLEGAL
    } instr_fmt_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] src_a;
        logic [31:0] src_b;
        logic [31:0] rs2_data;
        logic [4:0]  rd;
        logic        rd_we;
        logic        illegal;
    } issue_pkt_t;

    // Classifies an instruction; LW shares the I format since it uses the
    // same operand and immediate shape as the I-type ALU operations.
    function automatic instr_fmt_e decode_fmt(input logic [6:0] op,
                                              input logic [2:0] f3,
                                              input logic [6:0] f7);
        instr_fmt_e fmt;
        fmt = FMT_ILLEGAL;
        case (op)
            OP_R: begin
                if ((f3 == F3_ADD_SUB && (f7 == F7_BASE || f7 == F7_ALT)) ||
                    ((f3 == F3_AND || f3 == F3_OR || f3 == F3_SLT) && f7 == F7_BASE))
                    fmt = FMT_R;
            end
            OP_I: begin
                if (f3 == F3_ADD_SUB || f3 == F3_AND || f3 == F3_OR || f3 == F3_SLT)
                    fmt = FMT_I;
            end
            OP_LW:   if (f3 == F3_WORD) fmt = FMT_I;
            OP_SW:   if (f3 == F3_WORD) fmt = FMT_S;
            OP_BEQ:  if (f3 == F3_BEQ)  fmt = FMT_B;
            OP_JAL:  fmt = FMT_J;
            default: fmt = FMT_ILLEGAL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 32x32 integer register file, two asynchronous read ports and one
// synchronous write port; x0 is hardwired to zero and everything clears on reset.
module alu_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs1_i,
    input  logic [4:0]  rs2_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o,
    input  logic        we_i,
    input  logic [4:0]  rd_i,
    input  logic [31:0] wd_i
);

    logic [31:0] regs_q [32];

    // Storage: cleared on reset, writes to x0 are silently dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (we_i && rd_i != 5'd0) begin
            regs_q[rd_i] <= wd_i;
        end
    end

    assign rs1_data_o = (rs1_i == 5'd0) ? 32'd0 : regs_q[rs1_i];
    assign rs2_data_o = (rs2_i == 5'd0) ? 32'd0 : regs_q[rs2_i];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: RV32I decode-and-issue stage feeding the ALU through a two-entry
// skid buffer. Optional feature: define ALU_ISSUE_BYPASS_EN to forward a
// same-cycle writeback into the captured operands instead of stalling.
module alu_issue
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_src_a,
    output logic [XLEN-1:0] out_src_b,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] rs1Data;
    logic [XLEN-1:0] rs2Data;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [XLEN-1:0] immI;
    logic [XLEN-1:0] immS;
    instr_fmt_e      fmt;
    logic            wbHit1;
    logic            wbHit2;
    logic            conflict;
    issue_pkt_t      newPkt;
    issue_pkt_t      mainPkt_q, mainPkt_d;
    issue_pkt_t      skidPkt_q, skidPkt_d;
    logic            mainValid_q, mainValid_d;
    logic            skidValid_q, skidValid_d;
    logic            ready_q;
    logic            accept;
    logic            drain;

    assign opcode = in_instr[6:0];
    assign rd     = in_instr[11:7];
    assign funct3 = in_instr[14:12];
    assign rs1    = in_instr[19:15];
    assign rs2    = in_instr[24:20];
    assign funct7 = in_instr[31:25];
    assign immI   = {{20{in_instr[31]}}, in_instr[31:20]};
    assign immS   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign fmt    = decode_fmt(opcode, funct3, funct7);

    alu_regfile u_regfile (
        .clk        (clk),
        .reset      (reset),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .rs1_data_o (rs1Data),
        .rs2_data_o (rs2Data),
        .we_i       (wb_en),
        .rd_i       (wb_rd),
        .wd_i       (wb_data)
    );

    // Operand fetch: either forward a same-cycle writeback or flag it as a stall.
    always_comb begin
        wbHit1 = wb_en && (wb_rd != 5'd0) && (wb_rd == rs1);
        wbHit2 = wb_en && (wb_rd != 5'd0) && (wb_rd == rs2);
`ifdef ALU_ISSUE_BYPASS_EN
        opA      = wbHit1 ? wb_data : rs1Data;
        opB      = wbHit2 ? wb_data : rs2Data;
        conflict = 1'b0;
`else
        opA      = rs1Data;
        opB      = rs2Data;
        conflict = (wbHit1 && fmt != FMT_J) ||
                   (wbHit2 && (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B));
`endif
    end

    // Packet assembly: pick sources by format, zero operands of illegal encodings.
    always_comb begin
        newPkt          = '0;
        newPkt.opcode   = opcode;
        newPkt.funct3   = funct3;
        newPkt.funct7   = funct7;
        newPkt.rd       = rd;
        newPkt.src_a    = opA;
        newPkt.rs2_data = opB;
        case (fmt)
            FMT_R, FMT_B: newPkt.src_b = opB;
            FMT_I:        newPkt.src_b = immI;
            FMT_S:        newPkt.src_b = immS;
            FMT_J: begin
                newPkt.src_a = in_pc;
                newPkt.src_b = 32'd4;
            end
            default: begin
                newPkt.src_a    = '0;
                newPkt.src_b    = '0;
                newPkt.rs2_data = '0;
                newPkt.illegal  = 1'b1;
            end
        endcase
        newPkt.rd_we = (fmt == FMT_R || fmt == FMT_I || fmt == FMT_J) && (rd != 5'd0);
    end

    assign in_ready = ready_q && !conflict;
    assign accept   = in_valid && in_ready;
    assign drain    = mainValid_q && out_ready;

    // Skid buffer steering: the skid entry refills main as soon as main drains,
    // so packets always leave in acceptance order.
    always_comb begin
        mainPkt_d   = mainPkt_q;
        mainValid_d = mainValid_q;
        skidPkt_d   = skidPkt_q;
        skidValid_d = skidValid_q;
        if (drain) begin
            if (skidValid_q) begin
                mainPkt_d   = skidPkt_q;
                skidValid_d = 1'b0;
            end else if (accept) begin
                mainPkt_d = newPkt;
            end else begin
                mainValid_d = 1'b0;
            end
        end else if (accept) begin
            if (mainValid_q) begin
                skidPkt_d   = newPkt;
                skidValid_d = 1'b1;
            end else begin
                mainPkt_d   = newPkt;
                mainValid_d = 1'b1;
            end
        end
    end

    // Buffer registers; ready is registered from the next skid occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mainPkt_q   <= '0;
            skidPkt_q   <= '0;
            mainValid_q <= 1'b0;
            skidValid_q <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            mainPkt_q   <= mainPkt_d;
            skidPkt_q   <= skidPkt_d;
            mainValid_q <= mainValid_d;
            skidValid_q <= skidValid_d;
            ready_q     <= !skidValid_d;
        end
    end

    assign out_valid    = mainValid_q;
    assign out_opcode   = mainPkt_q.opcode;
    assign out_funct3   = mainPkt_q.funct3;
    assign out_funct7   = mainPkt_q.funct7;
    assign out_src_a    = mainPkt_q.src_a;
    assign out_src_b    = mainPkt_q.src_b;
    assign out_rs2_data = mainPkt_q.rs2_data;
    assign out_rd       = mainPkt_q.rd;
    assign out_rd_we    = mainPkt_q.rd_we;
    assign out_illegal  = mainPkt_q.illegal;

endmodule
